// File: rtl/seg_s2p_hex_encoder.sv
// -----------------------------------------------------------------------------
// seg_s2p_hex_encoder
//   Receive end of the segment serial link. Captures frames shifted out by the
//   segment P2S transmitter, rebuilds one 8-bit active-low segment pattern per
//   digit and encodes each pattern back to its hex nibble plus decimal point.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          asynchronous active-high reset
//   ser_clk      link shift clock (async to clk), data taken on its rising edge
//   ser_dat      link serial data
//   ser_latch    link frame-end strobe, rising edge ends the frame
//   hex_out      decoded nibbles, digit i at [4i+3:4i]
//   dp_out       decimal point per digit, 1 = lit
//   code_err     1 = digit pattern not in the encode table
//   frame_valid  one-cycle pulse, outputs updated from a good frame
//   frame_err    one-cycle pulse, frame ended with a wrong bit count
// -----------------------------------------------------------------------------
module seg_s2p_hex_encoder #(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ser_clk,
  input  logic                ser_dat,
  input  logic                ser_latch,
  output logic [4*DIGITS-1:0] hex_out,
  output logic [DIGITS-1:0]   dp_out,
  output logic [DIGITS-1:0]   code_err,
  output logic                frame_valid,
  output logic                frame_err
);

  localparam int FRAME_BITS = 8 * DIGITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       err;
  } enc_t;

  // Active-low gfedcba pattern back to its hex digit.
  function automatic enc_t encode(input logic [6:0] pat);
    enc_t e;
    e.err = 1'b0;
    unique case (pat)
      7'h40: e.nib = 4'h0;
      7'h79: e.nib = 4'h1;
      7'h24: e.nib = 4'h2;
      7'h30: e.nib = 4'h3;
      7'h19: e.nib = 4'h4;
      7'h12: e.nib = 4'h5;
      7'h02: e.nib = 4'h6;
      7'h78: e.nib = 4'h7;
      7'h00: e.nib = 4'h8;
      7'h10: e.nib = 4'h9;
      7'h08: e.nib = 4'hA;
      7'h03: e.nib = 4'hB;
      7'h46: e.nib = 4'hC;
      7'h21: e.nib = 4'hD;
      7'h06: e.nib = 4'hE;
      7'h0E: e.nib = 4'hF;
      default: begin
        e.nib = 4'h0;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Link inputs packed as {latch, dat, clk}.
  logic [2:0] meta, sync, sync_d;
  logic       clk_rise, latch_rise, dat_q;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        count, count_next;
  logic [FRAME_BITS-1:0]   shift, shift_next;
  logic                    load, bad;
  logic [4*DIGITS-1:0]     hex_next;
  logic [DIGITS-1:0]       dp_next, err_next;

  // Two-FF synchronizer, then a registered edge detect. The extra register
  // places the frame action at latch edge k+3; dat_q is delayed alongside so
  // it stays aligned with clk_rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta       <= '0;
      sync       <= '0;
      sync_d     <= '0;
      clk_rise   <= 1'b0;
      latch_rise <= 1'b0;
      dat_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would collapse the synchronizer chain into one stage.
      meta       <= {ser_latch, ser_dat, ser_clk};
      sync       <= meta;
      sync_d     <= sync;
      clk_rise   <= sync[0] & ~sync_d[0];
      latch_rise <= sync[2] & ~sync_d[2];
      dat_q      <= sync[1];
    end
  end

  // Next-state logic. The shift is applied before the latch check so a bit
  // arriving on the same cycle as the latch is counted in the frame.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which
    // would otherwise infer a latch.
    state_next = state;
    count_next = count;
    shift_next = shift;
    load       = 1'b0;
    bad        = 1'b0;

    if (clk_rise) begin
      shift_next = {shift[FRAME_BITS-2:0], dat_q};
      if (count != CNT_OVF) count_next = count + 1'b1;
      state_next = SHIFT;
    end

    if (latch_rise) begin
      // Covers the empty frame from IDLE too: count_next is then 0 (or 1).
      if (count_next == CNT_FULL) load = 1'b1;
      else                        bad  = 1'b1;
      count_next = '0;
      state_next = IDLE;
    end
  end

  // Decode every digit from the post-shift register contents.
  always_comb begin
    hex_next = '0;
    dp_next  = '0;
    err_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      enc_t e;
      e = encode(shift_next[8*i +: 7]);
      hex_next[4*i +: 4] = e.nib;
      err_next[i]        = e.err;
      dp_next[i]         = ~shift_next[8*i + 7];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      // NOTE: the shift register is reset so a frame cut by reset can never
      // leak stale bits into a later decode.
      shift       <= '0;
      hex_out     <= '0;
      dp_out      <= '0;
      code_err    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      shift       <= shift_next;
      frame_valid <= load;
      frame_err   <= bad;
      if (load) begin
        hex_out  <= hex_next;
        dp_out   <= dp_next;
        code_err <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_seg_s2p_hex_encoder.sv
module tb_seg_s2p_hex_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser_clk = 1'b0;
  logic        ser_dat = 1'b0;
  logic        ser_latch = 1'b0;
  logic [31:0] hex_out;
  logic [7:0]  dp_out;
  logic [7:0]  code_err;
  logic        frame_valid;
  logic        frame_err;

  int total = 0;
  int bad = 0;

  seg_s2p_hex_encoder #(.DIGITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ser_clk     (ser_clk),
    .ser_dat     (ser_dat),
    .ser_latch   (ser_latch),
    .hex_out     (hex_out),
    .dp_out      (dp_out),
    .code_err    (code_err),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Active-low gfedcba segment patterns for 0..F.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_frame(input logic [31:0] hex, input logic [7:0] dp);
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[8*i +: 8] = {~dp[i], seg_tab[hex[4*i +: 4]]};
    return f;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    ser_dat = b;
    repeat (4) @(negedge clk);
    ser_clk = 1'b1;
    repeat (4) @(negedge clk);
    ser_clk = 1'b0;
  endtask

  // Sends v[n-1] first, down to v[0].
  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  // Raises ser_latch (and optionally ser_clk on the same edge) and watches
  // ten cycles. cyc is the first pulse index counted from the edge that
  // first samples the latch high (that edge is index 0).
  task automatic latch_watch(input bit with_clk, output int cyc, output int vcnt, output int ecnt);
    cyc = -1;
    vcnt = 0;
    ecnt = 0;
    @(negedge clk);
    ser_latch = 1'b1;
    if (with_clk) ser_clk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (frame_valid) vcnt++;
      if (frame_err) ecnt++;
      if ((frame_valid || frame_err) && cyc < 0) cyc = i;
    end
    @(negedge clk);
    ser_latch = 1'b0;
    ser_clk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  int cyc, vcnt, ecnt;
  logic [63:0] f;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hex", hex_out, 32'h0);
    check("rst_dp", {24'h0, dp_out}, 32'h0);
    check("rst_cerr", {24'h0, code_err}, 32'h0);
    check("rst_pulses", {30'h0, frame_valid, frame_err}, 32'h0);

    // Basic frame 7..0, all dp off.
    send_bits(mk_frame(32'h76543210, 8'h00), 64);
    latch_watch(1'b0, cyc, vcnt, ecnt);
    check("t1_hex", hex_out, 32'h76543210);
    check("t1_dp", {24'h0, dp_out}, 32'h0);
    check("t1_cerr", {24'h0, code_err}, 32'h0);
    check("t1_cyc", cyc, 3);
    check("t1_vcnt", vcnt, 1);
    check("t1_ecnt", ecnt, 0);

    // DEADBEEF with digit 0 dp lit.
    send_bits(mk_frame(32'hDEADBEEF, 8'h01), 64);
    latch_watch(1'b0, cyc, vcnt, ecnt);
    check("t2_hex", hex_out, 32'hDEADBEEF);
    check("t2_dp", {24'h0, dp_out}, 32'h01);
    check("t2_vcnt", vcnt, 1);

    // Digit 3 blank (8'hFF): unknown pattern, dp off.
    f = mk_frame(32'h76543210, 8'h00);
    f[31:24] = 8'hFF;
    send_bits(f, 64);
    latch_watch(1'b0, cyc, vcnt, ecnt);
    check("t3_hex", hex_out, 32'h76540210);
    check("t3_cerr", {24'h0, code_err}, 32'h08);
    check("t3_dp", {24'h0, dp_out}, 32'h0);
    check("t3_vcnt", vcnt, 1);

    // Short frame: 63 bits.
    send_bits(mk_frame(32'h11111111, 8'h00), 63);
    latch_watch(1'b0, cyc, vcnt, ecnt);
    check("t4_ecnt", ecnt, 1);
    check("t4_vcnt", vcnt, 0);
    check("t4_cyc", cyc, 3);
    check("t4_hex", hex_out, 32'h76540210);
    check("t4_cerr", {24'h0, code_err}, 32'h08);

    // Long frame: 70 bits.
    send_bits(64'h0, 6);
    send_bits(mk_frame(32'h22222222, 8'h00), 64);
    latch_watch(1'b0, cyc, vcnt, ecnt);
    check("t5_ecnt", ecnt, 1);
    check("t5_vcnt", vcnt, 0);
    check("t5_hex", hex_out, 32'h76540210);

    // Recovery frame.
    send_bits(mk_frame(32'h89ABCDEF, 8'h80), 64);
    latch_watch(1'b0, cyc, vcnt, ecnt);
    check("t6_hex", hex_out, 32'h89ABCDEF);
    check("t6_dp", {24'h0, dp_out}, 32'h80);
    check("t6_cerr", {24'h0, code_err}, 32'h0);
    check("t6_vcnt", vcnt, 1);
    check("t6_ecnt", ecnt, 0);

    // Last ser_clk rise on the same edge as the latch rise.
    f = mk_frame(32'h13579BDF, 8'h00);
    send_bits(f >> 1, 63);
    @(negedge clk);
    ser_dat = f[0];
    repeat (4) @(negedge clk);
    latch_watch(1'b1, cyc, vcnt, ecnt);
    check("t7_hex", hex_out, 32'h13579BDF);
    check("t7_vcnt", vcnt, 1);
    check("t7_ecnt", ecnt, 0);

    // Reset in the middle of a frame.
    send_bits(mk_frame(32'hFFFFFFFF, 8'hFF), 30);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t8_rst_hex", hex_out, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(mk_frame(32'h2468ACE0, 8'h00), 64);
    latch_watch(1'b0, cyc, vcnt, ecnt);
    check("t8_hex", hex_out, 32'h2468ACE0);
    check("t8_vcnt", vcnt, 1);
    check("t8_ecnt", ecnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
